// File: rtl/alu_if.sv
// Operand, opcode and result bundle of the RV32I ALU.
// The datapath drives it as master; the ALU connects as slave.
interface alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic [31:0] ALURes;
    logic [31:0] ALUResQ;
    logic        Zero;
    logic        Neg;
    logic        Ovf;

    modport master (
        output A,
        output B,
        output ALUOp,
        input  ALURes,
        input  ALUResQ,
        input  Zero,
        input  Neg,
        input  Ovf
    );

    modport slave (
        input  A,
        input  B,
        input  ALUOp,
        output ALURes,
        output ALUResQ,
        output Zero,
        output Neg,
        output Ovf
    );
endinterface

// File: rtl/alu.sv
// 32-bit RV32I ALU: combinational result plus a registered copy for the next cycle.
// Define ALU_FLAGS_EN to build the Zero/Neg/Ovf flag registers; otherwise they read 0.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_SRA  = 4'b1101
    } alu_op_t;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic [31:0] res_q;

    assign sum   = bus.A + bus.B;
    assign diff  = bus.A - bus.B;
    assign shamt = bus.B[4:0];

    // Undefined opcodes fall through to the zero default.
    always_comb begin
        res = '0;
        case (alu_op_t'(bus.ALUOp))
            OP_ADD:  res = sum;
            OP_SUB:  res = diff;
            OP_SLL:  res = bus.A << shamt;
            OP_SLT:  res = {31'b0, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU: res = {31'b0, bus.A < bus.B};
            OP_XOR:  res = bus.A ^ bus.B;
            OP_SRL:  res = bus.A >> shamt;
            OP_SRA:  res = $unsigned($signed(bus.A) >>> shamt);
            OP_OR:   res = bus.A | bus.B;
            OP_AND:  res = bus.A & bus.B;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res;
        end
    end

    assign bus.ALURes  = res;
    assign bus.ALUResQ = res_q;

`ifdef ALU_FLAGS_EN
    logic ovf;
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    // Overflow only has meaning for ADD/SUB; every other opcode reports 0.
    always_comb begin
        ovf = 1'b0;
        case (bus.ALUOp)
            OP_ADD:  ovf = (bus.A[31] == bus.B[31]) && (sum[31] != bus.A[31]);
            OP_SUB:  ovf = (bus.A[31] != bus.B[31]) && (diff[31] != bus.A[31]);
            default: ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= (res == 32'd0);
            neg_q  <= res[31];
            ovf_q  <= ovf;
        end
    end

    assign bus.Zero = zero_q;
    assign bus.Neg  = neg_q;
    assign bus.Ovf  = ovf_q;
`else
    assign bus.Zero = 1'b0;
    assign bus.Neg  = 1'b0;
    assign bus.Ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues expected results from a reference model,
// and a monitor compares combinational and registered outputs each cycle.
module tb_alu;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [31:0] resq;
        logic        zero;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    exp_t scb[$];

    alu_if bus();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the opcode table.
    function automatic logic [31:0] modelRes(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd1:    return a << sh;
            4'd2:    return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd3:    return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd13:   return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd6:    return a | b;
            4'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic modelOvf(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        longint r;
        if (op == 4'd0)      r = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd8) r = longint'($signed(a)) - longint'($signed(b));
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic r);
        exp_t e;
        @(posedge clk);
        #2;
        bus.A     = a;
        bus.B     = b;
        bus.ALUOp = op;
        rst       = r;
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.res = modelRes(a, b, op);
        e.resq = r ? 32'd0 : e.res;
`ifdef ALU_FLAGS_EN
        e.zero = !r && (e.res == 32'd0);
        e.neg  = !r && e.res[31];
        e.ovf  = !r && modelOvf(a, b, op);
`else
        e.zero = 1'b0;
        e.neg  = 1'b0;
        e.ovf  = 1'b0;
`endif
        scb.push_back(e);
    endtask

    // Monitor: combinational result mid-cycle, registered copy just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scb.size() != 0) begin
                e = scb[0];
                checkOutput($sformatf("ALURes op=%b a=%h b=%h", e.op, e.a, e.b), bus.ALURes, e.res);
                @(posedge clk);
                #1;
                checkOutput($sformatf("ALUResQ op=%b", e.op), bus.ALUResQ, e.resq);
                checkOutput($sformatf("Zero op=%b", e.op), {31'b0, bus.Zero}, {31'b0, e.zero});
                checkOutput($sformatf("Neg op=%b", e.op), {31'b0, bus.Neg}, {31'b0, e.neg});
                checkOutput($sformatf("Ovf op=%b", e.op), {31'b0, bus.Ovf}, {31'b0, e.ovf});
                void'(scb.pop_front());
            end
        end
    end

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int wait_cycles;
        checks    = 0;
        passed    = 0;
        rst       = 1'b1;
        bus.A     = '0;
        bus.B     = '0;
        bus.ALUOp = '0;

        applyStimulus(32'd0, 32'd0, 4'b0000, 1'b1);
        applyStimulus(32'd0, 32'd0, 4'b0000, 1'b0);
        applyStimulus(32'd3, 32'd5, 4'b0000, 1'b0);
        applyStimulus(32'd3, 32'd5, 4'b1000, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 4'b0000, 1'b0);
        applyStimulus(32'd1, 32'd2, 4'b0001, 1'b0);
        applyStimulus(32'd4, 32'd1, 4'b0101, 1'b0);
        applyStimulus(32'hFFFF_FFF8, 32'd2, 4'b1101, 1'b0);
        applyStimulus(32'h8000_0000, 32'h21, 4'b0101, 1'b0);
        applyStimulus(32'h1234_5678, 32'd0, 4'b1101, 1'b0);
        applyStimulus(32'hFFFF_FFFE, 32'd3, 4'b0010, 1'b0);
        applyStimulus(32'hFFFF_FFFE, 32'd3, 4'b0011, 1'b0);
        applyStimulus(32'd2, 32'd3, 4'b0011, 1'b0);
        applyStimulus(32'd3, 32'd6, 4'b0100, 1'b0);
        applyStimulus(32'd3, 32'd6, 4'b0110, 1'b0);
        applyStimulus(32'd3, 32'd6, 4'b0111, 1'b0);
        applyStimulus(32'd3, 32'd6, 4'b1111, 1'b0);
        applyStimulus(32'hDEAD_BEEF, 32'h1, 4'b1010, 1'b0);
        // Mid-operation reset: registers clear while ALURes keeps following its inputs.
        applyStimulus(32'hFFFF_FFF0, 32'd5, 4'b0000, 1'b0);
        applyStimulus(32'hFFFF_FFF0, 32'd5, 4'b0000, 1'b1);
        applyStimulus(32'h8000_0000, 32'd1, 4'b1000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 19) == 0));
        end

        wait_cycles = 0;
        while (scb.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        if (scb.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
